// File: rtl/icache_refill_if.sv
// Bundle of the cache-side and memory-side signals of the instruction-cache refill engine.
// The refill engine connects through the master modport; the cache/memory environment uses slave.
interface icache_refill_if;
  // Handshakes: cache_miss is a level request sampled only while the engine is idle.
  // mem_req is held with a stable mem_addr until mem_rvalid is seen, and that single
  // mem_rvalid cycle completes the read. fetch is a one-cycle strobe that qualifies
  // write_addr/write_data. There is no backpressure on the cache write port.
  logic        cache_miss;
  logic [19:0] miss_addr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fetch;
  logic [19:0] write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        refill_done;
  logic        refill_error;
  logic [2:0]  dbg_state;

  modport master (
    input  cache_miss, miss_addr, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, fetch, write_addr, write_data,
    output busy, refill_done, refill_error, dbg_state
  );

  modport slave (
    output cache_miss, miss_addr, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, fetch, write_addr, write_data,
    input  busy, refill_done, refill_error, dbg_state
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: reads REFILL_WORDS sequential words from backing memory
// and writes each one into the cache, aborting with refill_error if memory stops answering.
module icache_refill #(
  parameter int REFILL_WORDS = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic            CLK_cpu,
  input  logic            RST_cpu,
  icache_refill_if.master bus
);

  localparam int              TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0]      LAST_WORD = 4'(REFILL_WORDS - 1);
  localparam logic [TW-1:0]   TO_LIMIT  = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [19:0]   base_q, base_d;
  logic [3:0]    word_cnt_q, word_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [19:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic [19:0]   req_addr;
  logic [TW-1:0] tmo_inc;

  // Sum is 20 bits wide, so a refill that runs past 0xFFFFC wraps to 0x00000.
  assign req_addr = base_q + {14'b0, word_cnt_q, 2'b00};
  assign tmo_inc  = tmo_cnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    word_cnt_d       = word_cnt_q;
    tmo_cnt_d        = tmo_cnt_q;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    bus.mem_req      = 1'b0;
    bus.mem_addr     = 20'h0;
    bus.fetch        = 1'b0;
    bus.busy         = 1'b0;
    bus.refill_done  = 1'b0;
    bus.refill_error = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cache_miss) begin
          base_d     = bus.miss_addr & 20'hFFFFC;
          word_cnt_d = 4'd0;
          tmo_cnt_d  = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = req_addr;
        if (bus.mem_rvalid) begin
          wr_addr_d = req_addr;
          wr_data_d = bus.mem_rdata;
          tmo_cnt_d = '0;
          state_d   = S_WRITE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if ((TIMEOUT != 0) && (tmo_inc == TO_LIMIT)) begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        bus.busy  = 1'b1;
        bus.fetch = 1'b1;
        if (word_cnt_q == LAST_WORD) begin
          state_d = S_DONE;
        end else begin
          word_cnt_d = word_cnt_q + 4'd1;
          state_d    = S_REQ;
        end
      end
      S_DONE: begin
        bus.busy        = 1'b1;
        bus.refill_done = 1'b1;
        state_d         = S_IDLE;
      end
      S_ERR: begin
        bus.busy         = 1'b1;
        bus.refill_error = 1'b1;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_cpu) begin
    if (RST_cpu) begin
      state_q    <= S_IDLE;
      base_q     <= 20'h0;
      word_cnt_q <= 4'd0;
      tmo_cnt_q  <= '0;
      wr_addr_q  <= 20'h0;
      wr_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_cnt_q <= word_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.write_addr = wr_addr_q;
  assign bus.write_data = wr_data_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: two instances (1-word refill with a short timeout, 4-word refill)
// driven with directed and random misses against a queue-based reference of expected cache writes.
module tb_icache_refill;

  localparam int W = 55;  // {dut id, kind, addr, data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_refill_if if0 ();
  icache_refill_if if1 ();

  icache_refill #(.REFILL_WORDS(1), .TIMEOUT(5)) dut0 (
    .CLK_cpu(clk), .RST_cpu(rst), .bus(if0.master)
  );
  icache_refill #(.REFILL_WORDS(4)) dut1 (
    .CLK_cpu(clk), .RST_cpu(rst), .bus(if1.master)
  );

  // Per-instance stimulus and observation arrays so tasks can index by dut id
  logic        miss_v[2];
  logic [19:0] maddr_v[2];
  logic        rvalid_v[2];
  logic [31:0] rdata_v[2];
  logic        req_o[2], fetch_o[2], busy_o[2], done_o[2], err_o[2];
  logic [19:0] memaddr_o[2], waddr_o[2];
  logic [31:0] wdata_o[2];
  logic [2:0]  state_o[2];

  assign if0.cache_miss = miss_v[0];
  assign if0.miss_addr  = maddr_v[0];
  assign if0.mem_rvalid = rvalid_v[0];
  assign if0.mem_rdata  = rdata_v[0];
  assign if1.cache_miss = miss_v[1];
  assign if1.miss_addr  = maddr_v[1];
  assign if1.mem_rvalid = rvalid_v[1];
  assign if1.mem_rdata  = rdata_v[1];

  assign req_o[0]     = if0.mem_req;      assign req_o[1]     = if1.mem_req;
  assign fetch_o[0]   = if0.fetch;        assign fetch_o[1]   = if1.fetch;
  assign busy_o[0]    = if0.busy;         assign busy_o[1]    = if1.busy;
  assign done_o[0]    = if0.refill_done;  assign done_o[1]    = if1.refill_done;
  assign err_o[0]     = if0.refill_error; assign err_o[1]     = if1.refill_error;
  assign memaddr_o[0] = if0.mem_addr;     assign memaddr_o[1] = if1.mem_addr;
  assign waddr_o[0]   = if0.write_addr;   assign waddr_o[1]   = if1.write_addr;
  assign wdata_o[0]   = if0.write_data;   assign wdata_o[1]   = if1.write_data;
  assign state_o[0]   = if0.dbg_state;    assign state_o[1]   = if1.dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] seed     = 32'h0;
  logic [W-1:0] exp_q[$];

  // Memory behaviour: wait_s = wait states per word (-1 never answers),
  // tie_m holds mem_rvalid high, spur_m adds random mem_rvalid while not requested.
  int wait_s[2] = '{0, 0};
  bit tie_m[2]  = '{1'b0, 1'b0};
  bit spur_m[2] = '{1'b0, 1'b0};

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return (32'(a) * 32'h9E3779B1) ^ seed;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a miss at address a produces `words` cache writes at consecutive
  // word addresses (wrapping at 1 MiB), each carrying that word's memory contents,
  // followed by one done; a timed-out miss produces only an error.
  task automatic model_refill(input int id, input logic [19:0] a, input int words, input bit tmo);
    logic [19:0] base;
    logic [19:0] wa;
    base = a & 20'hFFFFC;
    if (tmo) begin
      exp_q.push_back({1'(id), 2'd3, 20'h0, 32'h0});
    end else begin
      for (int i = 0; i < words; i++) begin
        wa = base + 20'(4 * i);
        exp_q.push_back({1'(id), 2'd1, wa, mem_word(wa)});
      end
      exp_q.push_back({1'(id), 2'd2, 20'h0, 32'h0});
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    int wcnt = 0;

    initial begin
      rvalid_v[g] = 1'b0;
      rdata_v[g]  = 32'h0;
      forever begin
        @(negedge clk);
        if (req_o[g] === 1'b1) begin
          if (tie_m[g] || (wait_s[g] >= 0 && wcnt == wait_s[g])) begin
            rvalid_v[g] = 1'b1;
            rdata_v[g]  = mem_word(memaddr_o[g]);
            wcnt        = 0;
          end else begin
            rvalid_v[g] = 1'b0;
            rdata_v[g]  = $urandom;
            wcnt++;
          end
        end else begin
          wcnt        = 0;
          rvalid_v[g] = tie_m[g] || (spur_m[g] && ($urandom_range(0, 1) == 1));
          rdata_v[g]  = $urandom;
        end
      end
    end

    initial begin
      logic         prev_f;
      logic [1:0]   kind;
      logic [W-1:0] act;
      logic [W-1:0] e;
      prev_f = 1'b0;
      forever begin
        @(negedge clk);
        if (fetch_o[g] === 1'b1 || done_o[g] === 1'b1 || err_o[g] === 1'b1) begin
          kind = ({fetch_o[g], done_o[g], err_o[g]} == 3'b100) ? 2'd1 :
                 ({fetch_o[g], done_o[g], err_o[g]} == 3'b010) ? 2'd2 :
                 ({fetch_o[g], done_o[g], err_o[g]} == 3'b001) ? 2'd3 : 2'd0;
          act = {1'(g), kind, (kind == 2'd1) ? waddr_o[g] : 20'h0,
                 (kind == 2'd1) ? wdata_o[g] : 32'h0};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got %h, required no event", g, act);
          end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
              n_fail++;
              $display("FAIL event dut%0d: got %h, required %h (t=%0t)", g, act, e, $time);
            end
          end
          if (fetch_o[g] === 1'b1) begin
            chk($sformatf("fetch_exclusive dut%0d", g), {62'h0, req_o[g], prev_f}, 64'h0);
          end
        end
        prev_f = fetch_o[g];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_miss(input int id, input logic [19:0] a);
    miss_v[id]  = 1'b1;
    maddr_v[id] = a;
    @(negedge clk);
    miss_v[id]  = 1'b0;
    maddr_v[id] = $urandom;
  endtask

  task automatic wait_idle(input int id, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy_o[id] !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain dut%0d: still busy=%b with %0d expected events after %0d cycles",
               id, busy_o[id], exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  task automatic chk_quiet(input int id, input string tag);
    chk($sformatf("%s_ctrl dut%0d", tag, id),
        {59'h0, req_o[id], fetch_o[id], busy_o[id], done_o[id], err_o[id]}, 64'h0);
    chk($sformatf("%s_addr dut%0d", tag, id), {24'h0, memaddr_o[id], waddr_o[id]}, 64'h0);
    chk($sformatf("%s_wdata dut%0d", tag, id), {32'h0, wdata_o[id]}, 64'h0);
    chk($sformatf("%s_state dut%0d", tag, id), {61'h0, state_o[id]}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    logic [19:0] b;
    int          k;
    int          reqs;
    int          id;
    bit          held;

    seed = $urandom;
    rst  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      miss_v[i]  = 1'b0;
      maddr_v[i] = 20'h0;
    end
    step(3);
    rst = 1'b0;
    chk_quiet(0, "reset");
    chk_quiet(1, "reset");

    // Single word, memory answering immediately: exact cycle-by-cycle profile
    tie_m[0] = 1'b1;
    model_refill(0, 20'h00123, 1, 1'b0);
    issue_miss(0, 20'h00123);
    chk("lat_c1", {60'h0, req_o[0], fetch_o[0], done_o[0], busy_o[0]}, 64'b1001);
    chk("lat_c1_mem_addr", {44'h0, memaddr_o[0]}, 64'h00120);
    step(1);
    chk("lat_c2", {60'h0, req_o[0], fetch_o[0], done_o[0], busy_o[0]}, 64'b0101);
    chk("lat_c2_write", {12'h0, waddr_o[0], wdata_o[0]}, {12'h0, 20'h00120, mem_word(20'h00120)});
    step(1);
    chk("lat_c3", {60'h0, req_o[0], fetch_o[0], done_o[0], busy_o[0]}, 64'b0011);
    step(1);
    chk("lat_c4", {60'h0, req_o[0], fetch_o[0], done_o[0], busy_o[0]}, 64'b0000);
    tie_m[0] = 1'b0;
    wait_idle(0, 20);

    // Four words with two wait states each, wrapping past the top of the address space
    wait_s[1] = 2;
    model_refill(1, 20'hFFFF8, 4, 1'b0);
    issue_miss(1, 20'hFFFF8);
    wait_idle(1, 200);

    // Memory never answers: five request cycles, then the error pulse
    wait_s[0] = -1;
    a = $urandom;
    model_refill(0, a, 1, 1'b1);
    issue_miss(0, a);
    reqs = 0;
    k    = 0;
    held = 1'b1;
    while (err_o[0] !== 1'b1 && k < 20) begin
      if (req_o[0] === 1'b1) begin
        reqs++;
        if (memaddr_o[0] !== (a & 20'hFFFFC)) held = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("timeout_req_cycles", 64'(reqs), 64'd5);
    chk("timeout_addr_held", {63'h0, held}, 64'h1);
    chk("timeout_err_cycle", {61'h0, busy_o[0], fetch_o[0], req_o[0]}, 64'b100);
    step(1);
    chk("timeout_after", {60'h0, busy_o[0], req_o[0], fetch_o[0], err_o[0]}, 64'h0);
    wait_s[0] = 0;
    wait_idle(0, 20);

    // Miss line toggled with new addresses while busy, then held across DONE
    wait_s[1] = $urandom_range(0, 3);
    a = $urandom;
    b = $urandom;
    model_refill(1, a, 4, 1'b0);
    issue_miss(1, a);
    k = 0;
    while (done_o[1] !== 1'b1 && k < 200) begin
      miss_v[1]  = ($urandom_range(0, 1) == 1);
      maddr_v[1] = $urandom;
      @(negedge clk);
      k++;
    end
    miss_v[1]  = 1'b1;
    maddr_v[1] = b;
    model_refill(1, b, 4, 1'b0);
    step(1);
    chk("rehit_idle_gap", {62'h0, busy_o[1], req_o[1]}, 64'h0);
    step(1);
    chk("rehit_second_req", {62'h0, busy_o[1], req_o[1]}, 64'b11);
    chk("rehit_second_addr", {44'h0, memaddr_o[1]}, {44'h0, b & 20'hFFFFC});
    miss_v[1] = 1'b0;
    wait_idle(1, 300);

    // Reset while a response is arriving: refill abandoned, nothing written
    tie_m[0] = 1'b1;
    issue_miss(0, $urandom);
    chk("prereset_req", {63'h0, req_o[0]}, 64'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_quiet(0, "midreset");
    step(1);
    chk("postreset_nofetch", {62'h0, fetch_o[0], busy_o[0]}, 64'h0);
    tie_m[0] = 1'b0;
    a = $urandom;
    model_refill(0, a, 1, 1'b0);
    issue_miss(0, a);
    wait_idle(0, 20);

    // Spurious read-valid pulses with no miss pending
    spur_m[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("spurious_idle", {61'h0, req_o[0], fetch_o[0], busy_o[0]}, 64'h0);
    end
    spur_m[0] = 1'b0;

    // Random misses on both instances, occasional memory stall on the short-timeout one
    for (int n = 0; n < 24; n++) begin
      id = $urandom_range(0, 1);
      a  = $urandom;
      if (id == 0 && $urandom_range(0, 4) == 0) begin
        wait_s[0] = -1;
        model_refill(0, a, 1, 1'b1);
      end else begin
        wait_s[id] = $urandom_range(0, 3);
        model_refill(id, a, (id == 0) ? 1 : 4, 1'b0);
      end
      issue_miss(id, a);
      wait_idle(id, 300);
      wait_s[id] = 0;
      step($urandom_range(0, 2));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss handler on the memory side of the 4-way instruction cache.
- When the cache reports a miss, this block fetches the missing 32-bit word from backing memory, plus optionally further sequential words.
- It writes each word into the cache through the cache's fetch/write port (fetch, write_addr, write_data).
- It holds busy so the CPU keeps read_en low while any fetch is in progress (read_en=1 with fetch=1 is illegal at the cache).

Parameters:
- REFILL_WORDS, 1, number of consecutive 4B words fetched per miss (1..16).
- TIMEOUT, 255, maximum cycles spent waiting for mem_rvalid per word; 0 disables the timeout.

Ports:
- CLK_cpu  input  1  system clock; all logic on rising edge.
- RST_cpu  input  1  synchronous, active-high reset.
- cache_miss  input  1  miss indication from the instruction cache.
- miss_addr  input  20  byte address of the missed instruction.
- mem_req  output  1  read request to backing memory.
- mem_addr  output  20  word-aligned read address; bits[1:0]=00.
- mem_rvalid  input  1  memory read data valid; completes the request.
- mem_rdata  input  32  memory read data.
- fetch  output  1  cache write strobe; high for exactly one cycle per word.
- write_addr  output  20  cache write address; bits[1:0]=00.
- write_data  output  32  cache write data.
- busy  output  1  refill in progress; CPU must hold read_en=0 while high.
- refill_done  output  1  one-cycle pulse on successful completion.
- refill_error  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state=IDLE. mem_req, fetch, busy, refill_done and refill_error are 0. mem_addr, write_addr and write_data are 0. Word and timeout counters are cleared.
- A reset in any state aborts the refill. No fetch is issued on the cycle after reset, and any pending memory response is ignored.

State machine:
- IDLE:
  - cache_miss=1 latches base = {miss_addr[19:2],2'b00}, clears word_cnt, and goes to REQ.
  - All outputs are 0.
- REQ:
  - busy=1, mem_req=1, mem_addr = base + 4*word_cnt, taken mod 2^20 (wraps from 0xFFFFC to 0x00000).
  - mem_addr is held stable while waiting.
  - mem_rvalid=1 (may occur in the first REQ cycle): capture mem_rdata and mem_addr, clear the timeout counter, go to WRITE.
  - Otherwise the timeout counter increments. If TIMEOUT≠0 and the count reaches TIMEOUT, go to ERR.
- WRITE:
  - busy=1, mem_req=0, fetch=1, with the captured write_addr and write_data.
  - If word_cnt = REFILL_WORDS-1, go to DONE. Otherwise increment word_cnt and go to REQ.
- DONE: busy=1, refill_done=1 for one cycle, then go to IDLE.
- ERR: busy=1, refill_error=1 for one cycle, no fetch, then go to IDLE. Words already written before the timeout remain in the cache.

Latency and handshake rules:
- Latency for REFILL_WORDS=1 with a zero-wait memory: cache_miss seen at cycle 0, mem_req at cycle 1, fetch at cycle 2, refill_done at cycle 3, IDLE at cycle 4.
- busy goes high the cycle after the miss is sampled and drops in the cycle after DONE/ERR.
- cache_miss and miss_addr are ignored outside IDLE; miss_addr is latched only in IDLE.
- A miss still asserted in the first IDLE cycle after DONE starts a new refill. Removing the miss is the CPU's job: it retries the read once busy is low.
- mem_rvalid outside REQ is ignored.
- fetch is never high in two consecutive cycles, and never high while mem_req is high.
- write_addr and write_data are held at their last values outside WRITE; they are qualified only by fetch.

Test Plan:
- Reset, then cache_miss=1 with miss_addr=0x00123 and mem_rvalid tied high, REFILL_WORDS=1:
  - mem_req at cycle 1 with mem_addr=0x00120.
  - fetch at cycle 2 with write_addr=0x00120 and write_data=mem_rdata.
  - refill_done at cycle 3.
  - busy=1 for cycles 1-3 only.
- REFILL_WORDS=4, miss_addr=0xFFFF8, memory with 2 wait states:
  - exactly 4 fetch pulses, to 0xFFFF8, 0xFFFFC, 0x00000, 0x00004, each with the matching data.
  - one refill_done pulse.
- TIMEOUT=5, mem_rvalid held low:
  - mem_req high for 5 cycles, then refill_error=1 for one cycle.
  - no fetch; IDLE with busy=0 on the next cycle.
- cache_miss toggled with a new miss_addr while busy:
  - the refill completes to the original address only.
  - cache_miss held high after DONE starts a second refill, with mem_req one cycle after IDLE.
- RST_cpu pulsed during REQ, with mem_rvalid=1 in the same cycle:
  - next cycle all outputs are 0 and state is IDLE.
  - no fetch occurs; a following miss refills normally.
- Spurious mem_rvalid pulses while in IDLE: mem_req, fetch and busy stay 0.
